// File: rtl/johnson_sample_decoder.sv
// Johnson-digit sample decoder: accepts one three-digit Johnson-coded sample
// per handshake, decodes it serially to binary 0..999, reports the modulo
// wrap difference from the previous good sample and flags illegal digit codes.
module johnson_sample_decoder #(
    parameter int unsigned pMOD         = 1000,
    parameter bit          pHOLD_ON_ERR = 1'b1
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_valid,
    output logic       o_ready,
    input  logic [4:0] i_100,
    input  logic [4:0] i_010,
    input  logic [4:0] i_001,
    output logic       o_valid,
    input  logic       i_ready,
    output logic [9:0] o_value,
    output logic [9:0] o_delta,
    output logic       o_first,
    output logic [2:0] o_err
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        DEC2 = 3'd1,
        DEC1 = 3'd2,
        DEC0 = 3'd3,
        OUT  = 3'd4
    } state_t;

    localparam logic [10:0] MOD_C = 11'(pMOD);

    // Johnson code to digit; bit 4 of the result is the illegal-code flag and
    // an illegal code decodes as digit 0.
    function automatic logic [4:0] johnson_dec(input logic [4:0] code);
        logic [4:0] res;
        case (code)
            5'b00000: res = {1'b0, 4'd0};
            5'b00001: res = {1'b0, 4'd1};
            5'b00011: res = {1'b0, 4'd2};
            5'b00111: res = {1'b0, 4'd3};
            5'b01111: res = {1'b0, 4'd4};
            5'b11111: res = {1'b0, 4'd5};
            5'b11110: res = {1'b0, 4'd6};
            5'b11100: res = {1'b0, 4'd7};
            5'b11000: res = {1'b0, 4'd8};
            5'b10000: res = {1'b0, 4'd9};
            default:  res = {1'b1, 4'd0};
        endcase
        return res;
    endfunction

    state_t      state_r;
    logic [4:0]  d100_r;
    logic [4:0]  d010_r;
    logic [4:0]  d001_r;
    logic [9:0]  acc_r;
    logic [9:0]  prev_r;
    logic        has_prev_r;
    logic [9:0]  value_r;
    logic [9:0]  delta_r;
    logic        first_r;
    logic [2:0]  err_r;
    logic        valid_r;
    logic        ready_r;

    logic [4:0]  dec100_s;
    logic [4:0]  dec010_s;
    logic [4:0]  dec001_s;
    logic [2:0]  err_s;
    logic [9:0]  new_value_s;
    logic [10:0] new_ext_s;
    logic [10:0] prev_ext_s;
    logic [10:0] delta_ext_s;
    logic        keep_prev_s;

    assign dec100_s = johnson_dec(d100_r);
    assign dec010_s = johnson_dec(d010_r);
    assign dec001_s = johnson_dec(d001_r);
    assign err_s    = {dec100_s[4], dec010_s[4], dec001_s[4]};

    // Final accumulation step and wrap-aware difference against the previous good value
    always_comb begin
        new_value_s = (acc_r * 10'd10) + {6'd0, dec001_s[3:0]};
        new_ext_s   = {1'b0, new_value_s};
        prev_ext_s  = {1'b0, prev_r};
        delta_ext_s = 11'd0;
        if (new_ext_s >= prev_ext_s) begin
            delta_ext_s = new_ext_s - prev_ext_s;
        end else begin
            delta_ext_s = (new_ext_s + MOD_C) - prev_ext_s;
        end
    end

    // An errored result only becomes the reference when errors are not held off
    always_comb begin
        keep_prev_s = 1'b0;
        if (pHOLD_ON_ERR && (err_r != 3'b000)) begin
            keep_prev_s = 1'b1;
        end else begin
            keep_prev_s = 1'b0;
        end
    end

    // Sample FSM: accept, three serial decode steps, then hold result until handshake
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r    <= IDLE;
            d100_r     <= 5'd0;
            d010_r     <= 5'd0;
            d001_r     <= 5'd0;
            acc_r      <= 10'd0;
            prev_r     <= 10'd0;
            has_prev_r <= 1'b0;
            value_r    <= 10'd0;
            delta_r    <= 10'd0;
            first_r    <= 1'b1;
            err_r      <= 3'b000;
            valid_r    <= 1'b0;
            ready_r    <= 1'b1;
        end else begin
            case (state_r)
                IDLE: begin
                    if (i_valid) begin
                        d100_r  <= i_100;
                        d010_r  <= i_010;
                        d001_r  <= i_001;
                        acc_r   <= 10'd0;
                        ready_r <= 1'b0;
                        state_r <= DEC2;
                    end else begin
                        ready_r <= 1'b1;
                        state_r <= IDLE;
                    end
                end
                DEC2: begin
                    acc_r   <= {6'd0, dec100_s[3:0]};
                    state_r <= DEC1;
                end
                DEC1: begin
                    acc_r   <= (acc_r * 10'd10) + {6'd0, dec010_s[3:0]};
                    state_r <= DEC0;
                end
                DEC0: begin
                    value_r <= new_value_s;
                    err_r   <= err_s;
                    if (has_prev_r) begin
                        delta_r <= delta_ext_s[9:0];
                        first_r <= 1'b0;
                    end else begin
                        delta_r <= 10'd0;
                        first_r <= 1'b1;
                    end
                    valid_r <= 1'b1;
                    state_r <= OUT;
                end
                OUT: begin
                    if (i_ready) begin
                        if (!keep_prev_s) begin
                            prev_r     <= value_r;
                            has_prev_r <= 1'b1;
                        end else begin
                            prev_r     <= prev_r;
                            has_prev_r <= has_prev_r;
                        end
                        valid_r <= 1'b0;
                        ready_r <= 1'b1;
                        state_r <= IDLE;
                    end else begin
                        state_r <= OUT;
                    end
                end
                default: begin
                    valid_r <= 1'b0;
                    ready_r <= 1'b1;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign o_ready = ready_r;
    assign o_valid = valid_r;
    assign o_value = value_r;
    assign o_delta = delta_r;
    assign o_first = first_r;
    assign o_err   = err_r;

endmodule

// File: tb/tb_johnson_sample_decoder.sv
// Directed table-driven bench for johnson_sample_decoder.
module tb_johnson_sample_decoder;

    logic       i_clk;
    logic       i_rst_n;
    logic       i_valid;
    logic       o_ready;
    logic [4:0] i_100;
    logic [4:0] i_010;
    logic [4:0] i_001;
    logic       o_valid;
    logic       i_ready;
    logic [9:0] o_value;
    logic [9:0] o_delta;
    logic       o_first;
    logic [2:0] o_err;

    int total;
    int bad;

    johnson_sample_decoder #(.pMOD(1000), .pHOLD_ON_ERR(1'b1)) dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .i_100   (i_100),
        .i_010   (i_010),
        .i_001   (i_001),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o_value (o_value),
        .o_delta (o_delta),
        .o_first (o_first),
        .o_err   (o_err)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    localparam logic [4:0] J0 = 5'b00000, J1 = 5'b00001, J2 = 5'b00011,
                           J3 = 5'b00111, J4 = 5'b01111, J5 = 5'b11111,
                           J6 = 5'b11110, J7 = 5'b11100, J8 = 5'b11000,
                           J9 = 5'b10000;

    typedef struct {
        logic [4:0] h;
        logic [4:0] t;
        logic [4:0] o;
        int         hold;
        int         ev;
        int         ed;
        int         ef;
        int         ee;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One full transaction: offer sample, check latency and result, optional
    // backpressure with ignored i_valid pulses, then handshake.
    task automatic apply(input vec_t v);
        int cnt;
        logic [9:0] sv;
        logic [9:0] sd;
        @(negedge i_clk);
        chk("ready_before_accept", int'(o_ready), 1);
        i_valid = 1'b1;
        i_100 = v.h; i_010 = v.t; i_001 = v.o;
        @(negedge i_clk);
        i_valid = 1'b0;
        i_100 = 5'b01010; i_010 = 5'b10101; i_001 = 5'b01010;
        chk("ready_low_after_accept", int'(o_ready), 0);
        cnt = 0;
        while (!o_valid && cnt < 12) begin
            @(negedge i_clk);
            cnt++;
        end
        chk("latency", cnt, 3);
        chk("value", int'(o_value), v.ev);
        chk("delta", int'(o_delta), v.ed);
        chk("first", int'(o_first), v.ef);
        chk("err", int'(o_err), v.ee);
        chk("ready_low_in_out", int'(o_ready), 0);
        sv = o_value;
        sd = o_delta;
        for (int k = 0; k < v.hold; k++) begin
            i_valid = k[0];
            i_100 = J9; i_010 = J9; i_001 = J9;
            @(negedge i_clk);
            chk("hold_valid", int'(o_valid), 1);
            chk("hold_ready", int'(o_ready), 0);
            chk("hold_value", int'(o_value), int'(sv));
            chk("hold_delta", int'(o_delta), int'(sd));
        end
        // i_valid is held high across the handshake when backpressure was used,
        // so the same-edge offer must not be accepted.
        i_valid = (v.hold > 0) ? 1'b1 : 1'b0;
        i_ready = 1'b1;
        @(negedge i_clk);
        i_ready = 1'b0;
        i_valid = 1'b0;
        chk("valid_low_after_hs", int'(o_valid), 0);
        chk("ready_high_after_hs", int'(o_ready), 1);
        @(negedge i_clk);
        chk("idle_ready", int'(o_ready), 1);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        i_rst_n = 1'b0;
        i_valid = 1'b0;
        i_ready = 1'b0;
        i_100 = J0; i_010 = J0; i_001 = J0;

        //           h   t         o   hold value delta first err
        vecs[0] = '{J3, J6,       J9, 0,  369,  0,   1, 0};
        vecs[1] = '{J4, J1,       J2, 0,  412,  43,  0, 0};
        vecs[2] = '{J9, J9,       J0, 10, 990,  578, 0, 0};
        vecs[3] = '{J0, J0,       J5, 0,  5,    15,  0, 0};
        vecs[4] = '{J7, 5'b01010, J8, 0,  708,  703, 0, 2};
        vecs[5] = '{J7, J1,       J0, 0,  710,  705, 0, 0};
        vecs[6] = '{5'b10101, 5'b01010, 5'b00100, 0, 0, 290, 0, 7};
        vecs[7] = '{J9, J9,       J9, 0,  999,  289, 0, 0};
        vecs[8] = '{J0, J0,       J0, 0,  0,    1,   0, 0};
        vecs[9] = '{J8, J2,       J7, 3,  827,  827, 0, 0};

        #12;
        chk("rst_valid", int'(o_valid), 0);
        chk("rst_value", int'(o_value), 0);
        chk("rst_delta", int'(o_delta), 0);
        chk("rst_first", int'(o_first), 1);
        chk("rst_err", int'(o_err), 0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        @(negedge i_clk);
        chk("rst_ready", int'(o_ready), 1);

        for (int i = 0; i < 10; i++) begin
            apply(vecs[i]);
        end

        // Asynchronous reset while in DEC1 discards the sample and history
        @(negedge i_clk);
        i_valid = 1'b1;
        i_100 = J5; i_010 = J5; i_001 = J5;
        @(negedge i_clk);
        i_valid = 1'b0;
        @(negedge i_clk);
        i_rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", int'(o_valid), 0);
        chk("mid_rst_first", int'(o_first), 1);
        chk("mid_rst_value", int'(o_value), 0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        apply('{J1, J2, J3, 0, 123, 0, 1, 0});
        apply('{J1, J2, J5, 0, 125, 2, 0, 0});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global watchdog so the run always terminates
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
